// File: rtl/softmax_pkg.sv
// Shared widths, fixed-point shift constants and FSM encoding for the softmax normalizer.
package softmax_pkg;
  localparam int unsigned N_ELEM      = 64;
  localparam int unsigned IN_W        = 16;
  localparam int unsigned SUM_W       = 24;
  localparam int unsigned OUT_W       = 16;
  localparam int unsigned RECIP_W     = 31;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned RECIP_SHIFT = 30;
  localparam int unsigned PROB_SHIFT  = 15;

  typedef enum logic [1:0] {
    IDLE,
    RECIP,
    SCALE,
    DONE
  } state_t;
endpackage

// File: rtl/recip_divider.sv
// Serial restoring divider computing floor(2^RECIP_SHIFT / divisor), one quotient bit per cycle.
module recip_divider #(
  parameter int unsigned DIV_W = 24,
  parameter int unsigned Q_W   = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);
  import softmax_pkg::*;

  localparam int unsigned CNT_W = $clog2(Q_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(Q_W);
  // The dividend is a single set bit, fed in on the step whose count matches its position.
  localparam logic [CNT_W-1:0] CNT_ONE_BIT = CNT_W'(RECIP_SHIFT + 1);

  logic [DIV_W-1:0] divisor_q;
  logic [DIV_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             running_q;
  logic [DIV_W:0]   trial;
  logic             fits;

  always_comb begin
    trial = {rem_q, (cnt_q == CNT_ONE_BIT)};
    fits  = (trial >= {1'b0, divisor_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        divisor_q <= divisor;
        rem_q     <= '0;
        quotient  <= '0;
        cnt_q     <= CNT_FULL;
        running_q <= 1'b1;
      end else if (running_q) begin
        rem_q    <= fits ? DIV_W'(trial - {1'b0, divisor_q}) : trial[DIV_W-1:0];
        quotient <= {quotient[Q_W-2:0], fits};
        cnt_q    <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          running_q <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/softmax_normalizer.sv
// Normalizes captured exp lanes by a serially computed reciprocal of their sum, streaming one lane per handshake.
module softmax_normalizer #(
  parameter int unsigned N_ELEM = 64,
  parameter int unsigned IN_W   = 16,
  parameter int unsigned SUM_W  = 24,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sum_valid_in,
  input  logic [SUM_W-1:0]         sum_in,
  input  logic [N_ELEM*IN_W-1:0]   exp_values_in,
  input  logic                     prob_ready,
  output logic                     prob_valid,
  output logic [OUT_W-1:0]         prob_out,
  output logic [5:0]               prob_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     div_by_zero,
  output logic                     overrun
);
  import softmax_pkg::*;

  localparam int unsigned PROD_W  = IN_W + RECIP_W;
  localparam int unsigned ROUND   = 1 << (PROB_SHIFT - 1);
  localparam int unsigned OUT_MAX = (1 << OUT_W) - 1;
  localparam logic [5:0]  LAST_IDX = 6'(N_ELEM - 1);

  state_t               state_q, state_d;
  logic [IN_W-1:0]      lane_q [N_ELEM];
  logic [SUM_W-1:0]     sum_q;
  logic [RECIP_W-1:0]   recip_q;
  logic [RECIP_W-1:0]   div_quot;
  logic                 div_done;
  logic                 capture;
  logic                 xfer;
  logic                 last_xfer;
  logic [IN_W-1:0]      lane_sel;
  logic [IN_W-1:0]      lane_pos;
  logic [PROD_W-1:0]    scaled;

  assign capture   = (state_q == IDLE) && sum_valid_in;
  assign xfer      = prob_valid && prob_ready;
  assign last_xfer = xfer && (prob_idx == LAST_IDX);

  recip_divider #(.DIV_W(SUM_W), .Q_W(RECIP_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (capture && (sum_in != '0)),
    .divisor  (sum_in),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (sum_valid_in) state_d = RECIP;
      RECIP: if (sum_q == '0 || div_done) state_d = SCALE;
      SCALE: if (last_xfer) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prob_valid = (state_q == SCALE);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    lane_sel   = lane_q[prob_idx];
    lane_pos   = lane_sel[IN_W-1] ? '0 : lane_sel;
    scaled     = (PROD_W'(lane_pos) * PROD_W'(recip_q) + PROD_W'(ROUND)) >> PROB_SHIFT;
    if (!prob_valid)                     prob_out = '0;
    else if (scaled > PROD_W'(OUT_MAX))  prob_out = '1;
    else                                 prob_out = scaled[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ELEM; i++) lane_q[i] <= '0;
      sum_q       <= '0;
      recip_q     <= '0;
      prob_idx    <= '0;
      div_by_zero <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= sum_valid_in && (state_q != IDLE);
      if (capture) begin
        for (int unsigned i = 0; i < N_ELEM; i++) lane_q[i] <= exp_values_in[i*IN_W +: IN_W];
        sum_q       <= sum_in;
        recip_q     <= '0;
        prob_idx    <= '0;
        div_by_zero <= 1'b0;
      end
      // A zero sum never starts the divider; recip stays at the 0 cleared on capture.
      if (state_q == RECIP) begin
        if (sum_q == '0)   div_by_zero <= 1'b1;
        else if (div_done) recip_q     <= div_quot;
      end
      if (xfer) prob_idx <= last_xfer ? '0 : prob_idx + 6'd1;
    end
  end
endmodule

// File: tb/tb_softmax_normalizer.sv
// Scoreboard bench for softmax_normalizer: table-driven jobs plus stall, overrun and reset sequences.
module tb_softmax_normalizer;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sum_valid_in = 1'b0;
  logic [23:0]   sum_in = '0;
  logic [1023:0] exp_values_in = '0;
  logic          prob_ready = 1'b1;
  logic          prob_valid;
  logic [15:0]   prob_out;
  logic [5:0]    prob_idx;
  logic          busy, done, div_by_zero, overrun;

  softmax_normalizer #(.N_ELEM(64), .IN_W(16), .SUM_W(24), .OUT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sum_valid_in  (sum_valid_in),
    .sum_in        (sum_in),
    .exp_values_in (exp_values_in),
    .prob_ready    (prob_ready),
    .prob_valid    (prob_valid),
    .prob_out      (prob_out),
    .prob_idx      (prob_idx),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sp_idx;
    logic [15:0] sp_val;
    logic [15:0] sp_exp;
    logic [15:0] rest;
    logic [15:0] rest_exp;
    logic [23:0] sum;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [5:0]  idx;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic        stall_q = 1'b0;
  logic [15:0] held_out = '0;
  logic [5:0]  held_idx = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && prob_valid) begin
        check("hold_out", 32'(prob_out), 32'(held_out));
        check("hold_idx", 32'(prob_idx), 32'(held_idx));
      end
      if (prob_valid && prob_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_lane: got idx %0d value 0x%0h, expected no transfer", prob_idx, prob_out);
        end else begin
          e = sb.pop_front();
          check("lane_idx", 32'(prob_idx), 32'(e.idx));
          check("lane_val", 32'(prob_out), 32'(e.val));
        end
      end
      stall_q  = prob_valid && !prob_ready;
      held_out = prob_out;
      held_idx = prob_idx;
    end
  end

  task automatic start_job(input vec_t v);
    exp_t t;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      exp_values_in[i*16 +: 16] = (i == v.sp_idx) ? v.sp_val : v.rest;
      t.idx = 6'(i);
      t.val = (i == v.sp_idx) ? v.sp_exp : v.rest_exp;
      sb.push_back(t);
    end
    sum_in = v.sum;
    sum_valid_in = 1'b1;
    @(posedge clk);
    #1 sum_valid_in = 1'b0;
    check("busy_after_capture", 32'(busy), 32'd1);
    check("no_overrun_on_capture", 32'(overrun), 32'd0);
  endtask

  task automatic wait_valid(input int exp_lat);
    int k = 0;
    while (!prob_valid && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    check("first_valid_latency", 32'(k), 32'(exp_lat));
    check("first_idx", 32'(prob_idx), 32'd0);
  endtask

  task automatic stream_to_done(input int exp_n);
    int n = 0;
    while (prob_valid && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("valid_run", 32'(n), 32'(exp_n));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    @(posedge clk);
    #1 check("done_cleared", 32'(done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_prob_valid"}, 32'(prob_valid), 32'd0);
    check({tag, "_prob_out"}, 32'(prob_out), 32'd0);
    check({tag, "_prob_idx"}, 32'(prob_idx), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   guard;

    vecs[0] = '{0, 16'h0400, 16'h0200, 16'h0400, 16'h0200, 24'h010000, 1'b0, 32};
    vecs[1] = '{0, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 24'h004000, 1'b0, 32};
    vecs[2] = '{0, 16'h0400, 16'h8000, 16'h0000, 16'h0000, 24'h000400, 1'b0, 32};
    vecs[3] = '{0, 16'h0400, 16'h0000, 16'h0400, 16'h0000, 24'h000000, 1'b1, 1};
    vecs[4] = '{0, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'hFFFF, 24'h000001, 1'b0, 32};
    vecs[5] = '{0, 16'h0001, 16'h0001, 16'h0400, 16'h0200, 24'h010000, 1'b0, 32};
    vecs[6] = '{63, 16'h8000, 16'h0000, 16'h0400, 16'h0200, 24'h010000, 1'b0, 32};
    vecs[7] = '{0, 16'h7FFF, 16'h0040, 16'h0400, 16'h0002, 24'hFFFFFF, 1'b0, 32};

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_job(vecs[i]);
      wait_valid(vecs[i].lat);
      check("div_by_zero", 32'(div_by_zero), 32'(vecs[i].dbz));
      stream_to_done(64);
    end

    // Stall at idx 10, overrun during RECIP, negative lane 5.
    v = '{5, 16'hFC00, 16'h0000, 16'h0400, 16'h0200, 24'h010000, 1'b0, 32};
    start_job(v);
    @(negedge clk);
    sum_in = 24'h000400;
    for (int i = 0; i < 64; i++) exp_values_in[i*16 +: 16] = 16'h7FFF;
    sum_valid_in = 1'b1;
    @(posedge clk);
    #1 sum_valid_in = 1'b0;
    check("overrun_pulse", 32'(overrun), 32'd1);
    @(posedge clk);
    #1 check("overrun_cleared", 32'(overrun), 32'd0);
    wait_valid(30);
    guard = 0;
    while (prob_idx != 6'd10 && guard < 100) begin
      @(posedge clk);
      #1 guard++;
    end
    check("reached_idx10", 32'(prob_idx), 32'd10);
    prob_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("stall_idx", 32'(prob_idx), 32'd10);
    check("stall_out", 32'(prob_out), 32'h0200);
    check("stall_valid", 32'(prob_valid), 32'd1);
    prob_ready = 1'b1;
    stream_to_done(54);

    // Reset in the middle of RECIP, then a fresh job.
    start_job(vecs[0]);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midjob_reset");
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("no_resume_busy", 32'(busy), 32'd0);
    check("no_resume_valid", 32'(prob_valid), 32'd0);
    start_job(vecs[2]);
    wait_valid(32);
    check("post_reset_dbz", 32'(div_by_zero), 32'd0);
    stream_to_done(64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/softmax_normalizer.md
SOFTMAX_NORMALIZER -- requirements
Module: softmax_normalizer

Interface
REQ-001 SHALL have parameters: N_ELEM, default 64, number of exp lanes; IN_W, default 16, S5.10 lane width; SUM_W, default 24, S13.10 sum width; OUT_W, default 16, Q1.15 probability width.
REQ-002 Ports: clk  input  1  system clock, rising-edge.
REQ-003 Ports: rst_n  input  1  asynchronous active-low reset.
REQ-004 Ports: sum_valid_in  input  1  one-cycle pulse; sum_in and exp_values_in are valid.
REQ-005 Ports: sum_in  input  SUM_W  S13.10 sum from tree_sum_accumulator, treated as unsigned.
REQ-006 Ports: exp_values_in  input  N_ELEM*IN_W  lane i at bits [i*16 +: 16], S5.10 signed.
REQ-007 Ports: prob_ready  input  1  downstream accepts prob_out this cycle.
REQ-008 Ports: prob_valid  output  1  prob_out and prob_idx are valid.
REQ-009 Ports: prob_out  output  OUT_W  normalized lane value, Q1.15 unsigned.
REQ-010 Ports: prob_idx  output  6  lane index of prob_out.
REQ-011 Ports: busy  output  1  high from capture until done.
REQ-012 Ports: done  output  1  one-cycle pulse after the last lane is accepted.
REQ-013 Ports: div_by_zero  output  1  sticky per job; high when the captured sum is 0.
REQ-014 Ports: overrun  output  1  one-cycle pulse when sum_valid_in arrives while busy.

Function
REQ-015 FSM states SHALL be IDLE, RECIP, SCALE, DONE.
REQ-016 In IDLE, sum_valid_in=1 SHALL latch sum_in and all lanes on that edge (capture edge E0), set busy, and clear div_by_zero.
REQ-017 RECIP SHALL compute recip = floor(2^30 / sum) as a 31-bit quotient by restoring division, one bit per cycle, over 31 cycles.
REQ-018 A captured sum of 0 SHALL skip RECIP, set div_by_zero, force recip=0, and enter SCALE directly; every lane then outputs 0x0000.
REQ-019 The first prob_valid SHALL assert after edge E32, or after E1 for a zero sum; prob_idx starts at 0.
REQ-020 Lane math: x = max(lane, 0); p = (x * recip + 2^14) >> 15; prob_out = min(p, 0xFFFF).
REQ-021 Handshake: a lane transfers on a cycle with prob_valid && prob_ready; prob_out and prob_idx SHALL hold stable while prob_valid && !prob_ready.
REQ-022 With prob_ready held high, SCALE SHALL emit one lane per cycle, i.e. 64 consecutive valid cycles.
REQ-023 On transfer of lane N_ELEM-1, the block SHALL drop prob_valid, go to DONE, pulse done for one cycle, then return to IDLE with busy=0.
REQ-024 sum_valid_in in any state other than IDLE SHALL be ignored (latched data unchanged) and SHALL pulse overrun.
REQ-025 sum_valid_in in the IDLE cycle immediately following DONE SHALL be accepted normally.

Reset
REQ-026 rst_n low SHALL, asynchronously and at any point including mid-RECIP or mid-SCALE, force state IDLE and all outputs to 0: prob_valid, prob_out, prob_idx, busy, done, div_by_zero, overrun.
REQ-027 Latched lane, sum and quotient registers SHALL reset to 0; no partial job resumes after reset release.

Structure
REQ-028 Package softmax_pkg SHALL hold N_ELEM, IN_W, SUM_W, OUT_W, RECIP_W=31, the FSM state enum, and the fixed-point shift constants (30, 15).
REQ-029 The serial divider SHALL be a separate sub-module, recip_divider, with start/done handshake and a 31-cycle fixed latency; the output multiply stays in the top module.

Verification
REQ-030 All lanes 0x0400 (1.0), sum 0x010000 (64.0) -> recip 16384; 64 lanes of 0x0200, idx 0..63, first valid 32 cycles after capture.
REQ-031 All lanes 0x0100 (0.25), sum 0x004000 (16.0) -> every prob_out 0x0200; one done pulse; busy low the next cycle.
REQ-032 Lane0 0x0400, others 0, sum 0x000400 -> lane0 0x8000, lanes 1..63 0x0000.
REQ-033 Sum 0 -> div_by_zero=1, 64 lanes of 0x0000, prob_valid one cycle after capture.
REQ-034 prob_ready low 5 cycles at idx 10; second sum_valid_in mid-job; lane 5 = 0xFC00 (-1.0) -> idx 10 held stable, overrun pulse, latched data unchanged, lane 5 output 0x0000.
REQ-035 rst_n asserted during RECIP, then a new job after release -> all outputs 0 immediately; new job results correct, with no stale lanes.
